// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider, 32-bit dividend by 16-bit divisor, one quotient bit per clock.
// Optional macro SEQDIV_ERR_CHECK_EN adds overflow / divide-by-zero detection with early exit.
module seq_divider_32by16 #(
    parameter int N  = 16,
    parameter int N2 = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N2-1:0] dividend,
    input  logic [N-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  quotient,
    output logic [N-1:0]  remainder,
    output logic          overflow,
    output logic          div_by_zero,
    output logic [1:0]    state_dbg
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [N-1:0]  prem;
    logic [N-1:0]  dvd_lo;
    logic [N-1:0]  div_q;
    logic [CW-1:0] count;
    logic [N:0]    rem_shift;
    logic          fits;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;

    // dvd_lo doubles as the quotient accumulator: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        rem_shift = {prem, dvd_lo[N-1]};
        fits      = rem_shift >= {1'b0, div_q};
        rem_next  = fits ? N'(rem_shift - {1'b0, div_q}) : rem_shift[N-1:0];
        quo_next  = {dvd_lo[N-2:0], fits};
    end

    assign state_dbg = state;

`ifdef SEQDIV_ERR_CHECK_EN
    logic ovf_q;
    logic dbz_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
`else
    assign overflow    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            prem      <= '0;
            dvd_lo    <= '0;
            div_q     <= '0;
            count     <= '0;
`ifdef SEQDIV_ERR_CHECK_EN
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_q  <= divisor;
                        prem   <= dividend[N2-1:N];
                        dvd_lo <= dividend[N-1:0];
                        count  <= CW'(N);
                        busy   <= 1'b1;
`ifdef SEQDIV_ERR_CHECK_EN
                        ovf_q  <= 1'b0;
                        dbz_q  <= 1'b0;
                        if (divisor == '0) begin
                            dbz_q     <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[N-1:0];
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (dividend[N2-1:N] >= divisor) begin
                            // Quotient cannot fit in N bits when the high half already reaches the divisor
                            ovf_q     <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    prem   <= rem_next;
                    dvd_lo <= quo_next;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        quotient  <= quo_next;
                        remainder <= rem_next;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
